// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM states and bus-level constants.
// Imported by the target engine and by future bus monitors.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with edge and START/STOP condition detection.
// All events derive from the synchronised copies only.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] synchroniser, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target engine with register-pointer protocol and host bank strobes.
// Samples on SCL rise, drives SDA on SCL fall, open-drain output.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         REG_AW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              ack_error
);

  import i2c_pkg::*;

  i2c_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              full_q, full_d;
  logic [7:0]        shift_q, shift_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              ack_err_q, ack_err_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic sda_s, scl_rise, scl_fall;
  logic start_det, stop_det;
  logic addr_hit;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (reset),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // general call (0x00) is never acknowledged
  assign addr_hit = (shift_q[7:1] == DEV_ADDR)
                  && (shift_q[7:1] != 7'h00);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    full_d    = full_q;
    shift_d   = shift_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    ack_err_d = ack_err_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    if (wr_en_q) addr_d = addr_q + 1'b1;
    // bank data is valid the clk after the fetch strobe
    if (rd_en_q) begin
      shift_d  = reg_rdata;
      sda_oe_d = ~reg_rdata[7];
    end

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      full_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      full_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (scl_rise) begin
      unique case (state_q)
        ADDR, PTR, WR_DATA: begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) full_d = 1'b1;
        end
        RD_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) full_d = 1'b1;
        end
        RD_ACK: begin
          addr_d = addr_q + 1'b1;
          if (sda_s == I2C_ACK) begin
            full_d = 1'b1;
          end else begin
            ack_err_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = IGNORE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        ADDR: if (full_q) begin
          full_d = 1'b0;
          if (addr_hit) begin
            sda_oe_d  = 1'b1;
            busy_d    = 1'b1;
            ack_err_d = 1'b0;
            state_d   = ADDR_ACK;
          end else begin
            state_d = IGNORE;
          end
        end
        ADDR_ACK: begin
          sda_oe_d = 1'b0;
          if (shift_q[0] == RW_WRITE) begin
            state_d = PTR;
          end else begin
            rd_en_d = 1'b1;
            state_d = RD_DATA;
          end
        end
        PTR: if (full_q) begin
          full_d   = 1'b0;
          sda_oe_d = 1'b1;
          addr_d   = REG_AW'(shift_q);
          state_d  = PTR_ACK;
        end
        WR_DATA: if (full_q) begin
          full_d   = 1'b0;
          sda_oe_d = 1'b1;
          wdata_d  = shift_q;
          wr_en_d  = 1'b1;
          state_d  = WR_ACK;
        end
        PTR_ACK, WR_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = WR_DATA;
        end
        RD_DATA: begin
          if (full_q) begin
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        RD_ACK: if (full_q) begin
          full_d  = 1'b0;
          rd_en_d = 1'b1;
          state_d = RD_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      full_q    <= 1'b0;
      shift_q   <= 8'h00;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      full_q    <= full_d;
      shift_q   <= shift_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      ack_err_q <= ack_err_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
  assign ack_error = ack_err_q;

endmodule
